fifo_ctrl: RTL

- Synchronous FIFO wrapper: owns the read/write pointers and flags for the 8×10 dual-port memory.
- The memory has so far been driven directly by a bench with explicit addresses and enables; this block generates `write_addr`/`read_addr`/`write_enable`/`read_enable` itself from push/pop requests.
- Sits between a producer (push side) and a consumer (pop side) in the datapath, with occupancy flags for upstream flow control.

---
 rtl/fifo_ctrl_pkg.sv | 8 +
 rtl/fifo_ctrl_memory.sv | 25 ++
 rtl/fifo_ctrl.sv | 62 ++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared defaults for the FIFO controller and its storage array
package fifo_ctrl_pkg;
    localparam int DEF_DATA_WIDTH   = 10;
    localparam int DEF_ADDR_WIDTH   = 3;
    localparam int DEF_DEPTH        = 1 << DEF_ADDR_WIDTH;
    localparam int DEF_ALMOST_FULL  = 6;
    localparam int DEF_ALMOST_EMPTY = 2;
endpackage

// File: rtl/fifo_ctrl_memory.sv
// memory: dual-port array with synchronous write and registered, resettable read port
module memory
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    output logic [DATA_WIDTH-1:0] Fifo_Data_out
);
    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk)
        if (write_enable) mem[write_addr] <= Fifo_Data_in;

    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) Fifo_Data_out <= '0;
        else if (read_enable) Fifo_Data_out <= mem[read_addr];
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO pointers, occupancy count, sticky error and flag decode
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL  = DEF_ALMOST_FULL,
    parameter int ALMOST_EMPTY = DEF_ALMOST_EMPTY
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  push_ok, pop_ok;

    // Occupancy alone decides full/empty, so the pointers may simply wrap
    assign full         = count == (ADDR_WIDTH+1)'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= (ADDR_WIDTH+1)'(ALMOST_FULL);
    assign almost_empty = count <= (ADDR_WIDTH+1)'(ALMOST_EMPTY);
    assign push_ok      = push && !full;
    assign pop_ok       = pop && !empty;

    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok != pop_ok) count <= push_ok ? count + 1'b1 : count - 1'b1;
            valid_out <= pop_ok;
            if ((push && full) || (pop && empty)) error <= 1'b1;
        end

    memory #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk          (clk),
        .reset_L      (reset_L),
        .write_addr   (wr_ptr),
        .read_addr    (rd_ptr),
        .write_enable (push_ok),
        .read_enable  (pop_ok),
        .Fifo_Data_in (data_in),
        .Fifo_Data_out(data_out)
    );
endmodule
